// File: rtl/udp_tx_packetizer_if.sv
// rtl/udp_tx_packetizer_if.sv - 32-bit stream bundle (tdata/tvalid/tready/tlast)
// master drives tdata/tvalid/tlast and samples tready; slave is the mirror.
interface udp_tx_packetizer_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/udp_tx_packetizer.sv
// rtl/udp_tx_packetizer.sv - cuts an untimed word stream into UDP payload packets
// Ports:
//   aclk, areset  : clock, synchronous active-high reset
//   s_axis        : source word stream (slave side, tlast forces end of packet)
//   m_axis        : registered payload stream to the Ethernet TX input
//   flush         : one-cycle request to close the open packet
//   pkt_done      : pulse after a tlast word handshakes on m_axis
//   timeout_evt   : pulse when a packet was closed by the idle timer
module udp_tx_packetizer #(
    parameter int MAX_WORDS      = 256,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                  aclk,
    input  logic                  areset,
    udp_tx_packetizer_if.slave    s_axis,
    udp_tx_packetizer_if.master   m_axis,
    input  logic                  flush,
    output logic                  pkt_done,
    output logic                  timeout_evt
);

    localparam int WCW = $clog2(MAX_WORDS + 1);
    localparam int ICW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WCW-1:0] LAST_IDX = WCW'(MAX_WORDS - 1);
    localparam logic [ICW-1:0] IDLE_MAX = ICW'(TIMEOUT_CYCLES);

    // holdback register: keeps one word back so tlast can still be attached
    logic [31:0]    hold_data_q,  hold_data_d;
    logic           hold_last_q,  hold_last_d;
    logic           hold_valid_q, hold_valid_d;

    logic [31:0]    out_data_q,   out_data_d;
    logic           out_last_q,   out_last_d;
    logic           out_valid_q,  out_valid_d;

    logic [WCW-1:0] word_cnt_q,   word_cnt_d;
    logic [ICW-1:0] idle_cnt_q,   idle_cnt_d;
    logic           flush_pend_q, flush_pend_d;
    logic           pkt_done_q,   pkt_done_d;
    logic           timeout_evt_q, timeout_evt_d;

    logic out_free;
    logic s_ready;
    logic accept;
    logic acc_final;
    logic timeout_hit;
    logic rel_now;
    logic rel_last;

    always_comb begin
        hold_data_d   = hold_data_q;
        hold_last_d   = hold_last_q;
        hold_valid_d  = hold_valid_q;
        out_data_d    = out_data_q;
        out_last_d    = out_last_q;
        out_valid_d   = out_valid_q;
        word_cnt_d    = word_cnt_q;
        idle_cnt_d    = idle_cnt_q;
        flush_pend_d  = flush_pend_q;

        out_free    = !out_valid_q || m_axis.tready;
        s_ready     = !hold_valid_q || out_free;
        accept      = s_axis.tvalid && s_ready;
        acc_final   = s_axis.tlast || (word_cnt_q == LAST_IDX);
        timeout_hit = (idle_cnt_q >= IDLE_MAX);

        rel_now = hold_valid_q && out_free &&
                  (accept || hold_last_q || timeout_hit || flush_pend_q);
        // A new word arriving keeps the packet open unless the held word was
        // already final; timeout/flush only close it when nothing arrives.
        rel_last = hold_last_q || !accept;

        pkt_done_d    = out_valid_q && m_axis.tready && out_last_q;
        timeout_evt_d = rel_now && !accept && !hold_last_q && timeout_hit;

        if (rel_now) begin
            out_data_d  = hold_data_q;
            out_last_d  = rel_last;
            out_valid_d = 1'b1;
        end else if (m_axis.tready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        if (accept) begin
            hold_data_d  = s_axis.tdata;
            hold_last_d  = acc_final;
            hold_valid_d = 1'b1;
        end else if (rel_now) begin
            hold_valid_d = 1'b0;
            hold_last_d  = 1'b0;
        end

        if (accept) begin
            word_cnt_d = acc_final ? '0 : word_cnt_q + 1'b1;
        end else if (rel_now && rel_last) begin
            word_cnt_d = '0;
        end

        if (accept || rel_now) begin
            idle_cnt_d = '0;
        end else if (hold_valid_q && !hold_last_q && !timeout_hit) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end

        // flush_pend survives a continuing accept; only a closing release clears it
        if (rel_now && rel_last) begin
            flush_pend_d = 1'b0;
        end else if (flush && hold_valid_q && !hold_last_q) begin
            flush_pend_d = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            hold_data_q   <= '0;
            hold_last_q   <= 1'b0;
            hold_valid_q  <= 1'b0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            word_cnt_q    <= '0;
            idle_cnt_q    <= '0;
            flush_pend_q  <= 1'b0;
            pkt_done_q    <= 1'b0;
            timeout_evt_q <= 1'b0;
        end else begin
            hold_data_q   <= hold_data_d;
            hold_last_q   <= hold_last_d;
            hold_valid_q  <= hold_valid_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
            out_valid_q   <= out_valid_d;
            word_cnt_q    <= word_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            flush_pend_q  <= flush_pend_d;
            pkt_done_q    <= pkt_done_d;
            timeout_evt_q <= timeout_evt_d;
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tdata  = out_data_q;
    assign m_axis.tvalid = out_valid_q;
    assign m_axis.tlast  = out_last_q;
    assign pkt_done      = pkt_done_q;
    assign timeout_evt   = timeout_evt_q;

endmodule

// File: tb/tb_udp_tx_packetizer.sv
// tb/tb_udp_tx_packetizer.sv - scoreboard bench for udp_tx_packetizer
module tb_udp_tx_packetizer;

    logic aclk = 1'b0;
    logic areset;
    logic flush;
    logic pkt_done;
    logic timeout_evt;

    udp_tx_packetizer_if s_if ();
    udp_tx_packetizer_if m_if ();

    udp_tx_packetizer #(
        .MAX_WORDS      (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .flush       (flush),
        .pkt_done    (pkt_done),
        .timeout_evt (timeout_evt)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   cyc        = 0;
    int   hs_cyc[256];
    int   hs_count   = 0;
    int   done_count = 0;
    int   tmo_count  = 0;
    int   acc_cyc    = 0;
    int   mcnt       = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // output monitor: pops the scoreboard on every m_axis handshake
    always @(negedge aclk) begin : monitor
        exp_t e;
        if (!areset) begin
            if (pkt_done)    done_count++;
            if (timeout_evt) tmo_count++;
            if (m_if.tvalid && m_if.tready) begin
                check_eq("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check_eq("m_tdata", m_if.tdata, e.data);
                    check_eq("m_tlast", {31'd0, m_if.tlast}, {31'd0, e.last});
                end
                hs_cyc[m_if.tdata[7:0]] = cyc;
                hs_count++;
            end
        end
    end

    // closes=1 marks a word the bench will follow by idle or flush
    task automatic send(input logic [31:0] d, input logic tl, input logic closes);
        int   n;
        logic last;
        s_if.tdata  = d;
        s_if.tvalid = 1'b1;
        s_if.tlast  = tl;
        n = 0;
        @(negedge aclk);
        while (!s_if.tready && n < 200) begin
            @(negedge aclk);
            n++;
        end
        check_eq("s_tready_wait", {31'd0, s_if.tready}, 32'd1);
        if (!s_if.tready) begin
            s_if.tvalid = 1'b0;
            return;
        end
        acc_cyc = cyc;
        last = tl || closes || (mcnt == 3);
        sb_q.push_back({d, last});
        mcnt = last ? 0 : mcnt + 1;
        @(posedge aclk);
        #1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || m_if.tvalid) && n < 200) begin
            @(negedge aclk);
            n++;
        end
        check_eq("drain_empty", sb_q.size(), 32'd0);
        tick(2);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int d0, t0, h0, a, stable;
        logic [31:0] held;

        areset      = 1'b1;
        flush       = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_eq("rst_m_tvalid", {31'd0, m_if.tvalid}, 32'd0);
        check_eq("rst_m_tlast", {31'd0, m_if.tlast}, 32'd0);
        check_eq("rst_m_tdata", m_if.tdata, 32'd0);
        check_eq("rst_pkt_done", {31'd0, pkt_done}, 32'd0);
        check_eq("rst_timeout_evt", {31'd0, timeout_evt}, 32'd0);
        check_eq("rst_s_tready", {31'd0, s_if.tready}, 32'd1);
        @(posedge aclk);
        #1 areset = 1'b0;

        // back-to-back words, packets cut at MAX_WORDS
        d0 = done_count;
        t0 = tmo_count;
        for (int i = 1; i <= 8; i++) send(i, 1'b0, 1'b0);
        drain();
        check_eq("t1_pkt_done", done_count - d0, 32'd2);
        check_eq("t1_no_gaps", hs_cyc[8] - hs_cyc[1], 32'd7);
        check_eq("t1_no_timeout", tmo_count - t0, 32'd0);

        // idle timeout closes a short packet
        t0 = tmo_count;
        send(32'hA, 1'b0, 1'b0);
        send(32'hB, 1'b0, 1'b0);
        send(32'hC, 1'b0, 1'b1);
        a = acc_cyc;
        drain();
        check_eq("t2_timeout_latency", hs_cyc[8'h0C] - a, 32'd18);
        check_eq("t2_timeout_evt", tmo_count - t0, 32'd1);

        // source tlast on the second word
        d0 = done_count;
        send(32'h1, 1'b0, 1'b0);
        send(32'h2, 1'b1, 1'b0);
        a = acc_cyc;
        for (int i = 3; i <= 6; i++) send(i, 1'b0, 1'b0);
        drain();
        check_eq("t3_final_latency", hs_cyc[2] - a, 32'd2);
        check_eq("t3_pkt_done", done_count - d0, 32'd2);

        // downstream stall mid-burst
        d0 = done_count;
        fork
            begin
                for (int i = 8'h11; i <= 8'h18; i++) send(i, 1'b0, 1'b0);
            end
            begin
                repeat (3) @(posedge aclk);
                #1 m_if.tready = 1'b0;
                @(negedge aclk);
                held   = m_if.tdata;
                stable = 1;
                repeat (10) begin
                    @(negedge aclk);
                    if (m_if.tdata !== held || !m_if.tvalid) stable = 0;
                end
                check_eq("t4_tdata_stable", stable, 32'd1);
                check_eq("t4_s_tready_low", {31'd0, s_if.tready}, 32'd0);
                check_eq("t4_m_tvalid_held", {31'd0, m_if.tvalid}, 32'd1);
                @(posedge aclk);
                #1 m_if.tready = 1'b1;
            end
        join
        drain();
        check_eq("t4_pkt_done", done_count - d0, 32'd2);

        // flush with an open packet, then flush with hold empty
        t0 = tmo_count;
        send(32'h5, 1'b0, 1'b1);
        a = acc_cyc;
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        drain();
        check_eq("t5_flush_latency", hs_cyc[5] - a, 32'd3);
        check_eq("t5_no_timeout_evt", tmo_count - t0, 32'd0);
        h0 = hs_count;
        tick(3);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        tick(25);
        check_eq("t5_empty_flush_quiet", hs_count - h0, 32'd0);
        check_eq("t5_empty_flush_tvalid", {31'd0, m_if.tvalid}, 32'd0);

        // reset mid-packet
        send(32'h61, 1'b0, 1'b0);
        send(32'h62, 1'b0, 1'b0);
        send(32'h63, 1'b0, 1'b0);
        tick(3);
        areset = 1'b1;
        sb_q.delete();
        mcnt = 0;
        tick(1);
        check_eq("t6_m_tvalid", {31'd0, m_if.tvalid}, 32'd0);
        check_eq("t6_m_tlast", {31'd0, m_if.tlast}, 32'd0);
        check_eq("t6_m_tdata", m_if.tdata, 32'd0);
        check_eq("t6_pkt_done", {31'd0, pkt_done}, 32'd0);
        check_eq("t6_timeout_evt", {31'd0, timeout_evt}, 32'd0);
        areset = 1'b0;
        tick(1);
        d0 = done_count;
        h0 = hs_count;
        for (int i = 8'h71; i <= 8'h74; i++) send(i, 1'b0, 1'b0);
        drain();
        check_eq("t6_one_packet", done_count - d0, 32'd1);
        check_eq("t6_word_count", hs_count - h0, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
